// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// pipeline_hazard_ctrl_if : hazard-detect inputs and stall/flush controls
// Rev 1.0
// ============================================================================
interface pipeline_hazard_ctrl_if #(
    parameter int PERF_W = 32
);
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic              id_reads_hilo;
    logic              id_mdu_start;
    logic              id_mdu_div;
    logic              ex_mem_read;
    logic [4:0]        ex_rt;
    logic              ex_branch_taken;
    logic              mem_ready;

    logic              pc_stall;
    logic              id_stall;
    logic              id_flush;
    logic              ex_stall;
    logic              ex_flush;
    logic              mem_stall;
    logic              mdu_busy;
    logic              mdu_done;
    logic [PERF_W-1:0] stall_cycles;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_reads_hilo,
               id_mdu_start, id_mdu_div, ex_mem_read, ex_rt,
               ex_branch_taken, mem_ready,
        input  pc_stall, id_stall, id_flush, ex_stall, ex_flush, mem_stall,
               mdu_busy, mdu_done, stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_reads_hilo,
               id_mdu_start, id_mdu_div, ex_mem_read, ex_rt,
               ex_branch_taken, mem_ready,
        output pc_stall, id_stall, id_flush, ex_stall, ex_flush, mem_stall,
               mdu_busy, mdu_done, stall_cycles
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// pipeline_hazard_ctrl : stall/flush controller with MDU occupancy tracking
// Rev 1.0
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6,
    parameter int PERF_W     = 32
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    pipeline_hazard_ctrl_if.slave hz
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_mul_load = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_div_load = CNT_W'(DIV_CYCLES - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_count;
    logic [PERF_W-1:0]  r_stall_cycles;

    logic w_busy;
    logic w_done;
    logic w_lu;
    logic w_mh;
    logic w_br;
    logic w_mw;
    logic w_accept;
    logic w_pc_stall;
    logic w_id_stall;
    logic w_id_flush;
    logic w_ex_stall;
    logic w_ex_flush;
    logic w_mem_stall;

    assign w_busy = (r_state == ST_BUSY);
    assign w_done = w_busy && (r_count == '0);

    assign w_lu = hz.ex_mem_read && (hz.ex_rt != 5'd0) &&
                  ((hz.id_uses_rs && (hz.id_rs == hz.ex_rt)) ||
                   (hz.id_uses_rt && (hz.id_rt == hz.ex_rt)));
    assign w_mh = w_busy && (hz.id_reads_hilo || hz.id_mdu_start);
    assign w_br = hz.ex_branch_taken;
    assign w_mw = !hz.mem_ready;

    // Only an MDU op that actually leaves ID may start the countdown.
    assign w_accept = hz.id_mdu_start && !w_mw && !w_br && !w_lu && !w_mh;

    always_comb begin
        w_pc_stall  = 1'b0;
        w_id_stall  = 1'b0;
        w_id_flush  = 1'b0;
        w_ex_stall  = 1'b0;
        w_ex_flush  = 1'b0;
        w_mem_stall = 1'b0;
        if (!rst_n) begin
            w_pc_stall = 1'b0;
        end else if (w_mw) begin
            // Whole pipe freezes; a taken branch stays in EX and flushes later.
            w_pc_stall  = 1'b1;
            w_id_stall  = 1'b1;
            w_ex_stall  = 1'b1;
            w_mem_stall = 1'b1;
        end else if (w_br) begin
            w_id_flush = 1'b1;
            w_ex_flush = 1'b1;
        end else if (w_mh || w_lu) begin
            w_pc_stall = 1'b1;
            w_id_stall = 1'b1;
            w_ex_flush = 1'b1;
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_BUSY;
                        r_count <= hz.id_mdu_div ? c_div_load : c_mul_load;
                    end
                end
                ST_BUSY: begin
                    if (r_count == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_count <= '0;
                end
            endcase
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
        end else if (w_pc_stall && (r_stall_cycles != {PERF_W{1'b1}})) begin
            r_stall_cycles <= r_stall_cycles + 1'b1;
        end
    end

    assign hz.pc_stall     = w_pc_stall;
    assign hz.id_stall     = w_id_stall;
    assign hz.id_flush     = w_id_flush;
    assign hz.ex_stall     = w_ex_stall;
    assign hz.ex_flush     = w_ex_flush;
    assign hz.mem_stall    = w_mem_stall;
    assign hz.mdu_busy     = w_busy;
    assign hz.mdu_done     = w_done;
    assign hz.stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire
